// File: rtl/sdram_port_sched.sv
// sdram_port_sched: arbitrates buffered ROM-download bytes against core ROM reads onto one toggle-handshake SDRAM port
// Ports: clk_sys/reset_n (async active-low); dl_* download stream in, dl_overflow/dl_done sticky status out;
//   rd_oe/rd_addr core read request, rd_data/rd_valid read result; mem_* toggle-handshake SDRAM port.
// Option: define SDRAM_SCHED_RDCACHE_EN to keep a one-word read tag and skip repeated reads of the same address.
module sdram_port_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW = 22
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          rd_oe,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic          rd_valid,
  output logic          dl_overflow,
  output logic          dl_done,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_ds,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;
  state_t state, state_nxt;
  logic [AW:0] fifo_addr [FIFO_DEPTH];
  logic [7:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic empty, full, push, pop, issue_rd, rd_pend, ack_match;
  logic dl_active_q, dl_rise, dl_fall, fall_seen;
  logic [AW:0] head_addr;
  logic [7:0] head_data;
  assign empty = cnt == '0;
  assign full = cnt == (PW+1)'(FIFO_DEPTH);
  // a full FIFO still accepts a byte in the cycle its head is popped
  assign push = dl_wr && (!full || pop);
  assign ack_match = mem_ack == mem_req;
  assign head_addr = fifo_addr[rp];
  assign head_data = fifo_data[rp];
  assign dl_rise = dl_active && !dl_active_q;
  assign dl_fall = !dl_active && dl_active_q;
  always_comb begin
    pop = state == IDLE && !empty;
    issue_rd = state == IDLE && empty && rd_pend && !dl_active;
    state_nxt = pop ? WR_WAIT : issue_rd ? RD_WAIT : (state != IDLE && ack_match) ? IDLE : state;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk_sys)
    if (push) begin
      fifo_addr[wp] <= dl_addr;
      fifo_data[wp] <= dl_data;
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_ds <= 2'b00;
      mem_din <= 16'h0;
      rd_data <= 16'h0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (pop) begin
        mem_req <= ~mem_req;
        mem_we <= 1'b1;
        mem_addr <= head_addr[AW:1];
        mem_ds <= {head_addr[0], ~head_addr[0]};
        mem_din <= {head_data, head_data};
      end else if (issue_rd) begin
        mem_req <= ~mem_req;
        mem_we <= 1'b0;
        mem_addr <= rd_addr;
        mem_ds <= 2'b11;
      end
      if (state == RD_WAIT && ack_match) begin
        rd_data <= mem_dout;
        rd_valid <= 1'b1;
      end
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      dl_active_q <= 1'b0;
      fall_seen <= 1'b0;
      dl_done <= 1'b0;
      dl_overflow <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      fall_seen <= dl_rise ? 1'b0 : (fall_seen || dl_fall);
      dl_done <= dl_rise ? 1'b0 : (dl_done || (fall_seen && !dl_active && empty && state == IDLE));
      dl_overflow <= dl_rise ? 1'b0 : (dl_overflow || (dl_wr && full && !pop));
    end
`ifdef SDRAM_SCHED_RDCACHE_EN
  logic c_valid;
  logic [AW-1:0] c_tag;
  assign rd_pend = rd_oe && (!c_valid || rd_addr != c_tag);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      c_valid <= 1'b0;
      c_tag <= '0;
    end else if (dl_rise) c_valid <= 1'b0;
    else if (issue_rd) begin
      c_valid <= 1'b1;
      c_tag <= rd_addr;
    end else if (pop && head_addr[AW:1] == c_tag) c_valid <= 1'b0;
`else
  logic rd_oe_q, rd_pend_q;
  assign rd_pend = rd_pend_q;
  // each rd_oe rising edge is remembered until its read is issued
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      rd_oe_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      rd_oe_q <= rd_oe;
      rd_pend_q <= (rd_pend_q && !issue_rd) || (rd_oe && !rd_oe_q);
    end
`endif
endmodule

// File: tb/tb_sdram_port_sched.sv
// tb_sdram_port_sched: scoreboard bench for sdram_port_sched with a latency-programmable SDRAM responder
module tb_sdram_port_sched;
  typedef struct {
    logic we;
    logic [21:0] addr;
    logic [1:0] ds;
    logic [15:0] din;
  } acc_t;
  logic clk_sys = 1'b0;
  logic reset_n, dl_active, dl_wr, rd_oe, rd_valid, dl_overflow, dl_done;
  logic mem_req, mem_ack, mem_we;
  logic [22:0] dl_addr;
  logic [7:0] dl_data;
  logic [21:0] rd_addr, mem_addr;
  logic [15:0] rd_data, mem_din, mem_dout;
  logic [1:0] mem_ds;
  int errors = 0, checks = 0, n_req = 0, n_rdv = 0, lat = 2;
  logic hold = 1'b0;
  acc_t exp_acc[$];
  logic [15:0] exp_rd[$];
  always #5 clk_sys = ~clk_sys;
  sdram_port_sched dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .rd_oe(rd_oe), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .dl_overflow(dl_overflow), .dl_done(dl_done),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ds(mem_ds), .mem_din(mem_din), .mem_dout(mem_dout)
  );
  function automatic acc_t wr_exp(logic [22:0] a, logic [7:0] d);
    return '{1'b1, a[22:1], {a[0], ~a[0]}, {d, d}};
  endfunction
  function automatic acc_t rd_exp(logic [21:0] a);
    return '{1'b0, a, 2'b11, 16'h0};
  endfunction
  task automatic responder();
    int c = 0;
    forever begin
      @(negedge clk_sys or negedge reset_n);
      if (!reset_n) begin
        mem_ack = 1'b0;
        c = 0;
      end else if (mem_req != mem_ack && !hold) begin
        if (c + 1 >= lat) begin
          mem_ack = mem_req;
          mem_dout = 16'h1234 ^ mem_addr[15:0];
          c = 0;
        end else c++;
      end
    end
  endtask
  task automatic monitor();
    logic req_last = 1'b0;
    acc_t e;
    logic [15:0] d;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) req_last = 1'b0;
      else begin
        if (mem_req != req_last) begin
          req_last = mem_req;
          n_req++;
          checks++;
          if (exp_acc.size() == 0) begin
            errors++;
            $display("FAIL access: unexpected we=%0b addr=%h ds=%b din=%h", mem_we, mem_addr, mem_ds, mem_din);
          end else begin
            e = exp_acc.pop_front();
            if ({mem_we, mem_addr, mem_ds} !== {e.we, e.addr, e.ds} || (e.we && mem_din !== e.din)) begin
              errors++;
              $display("FAIL access: got we=%0b addr=%h ds=%b din=%h want we=%0b addr=%h ds=%b din=%h",
                       mem_we, mem_addr, mem_ds, mem_din, e.we, e.addr, e.ds, e.din);
            end
          end
        end
        if (rd_valid) begin
          n_rdv++;
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL rd_valid: unexpected pulse rd_data=%h", rd_data);
          end else begin
            d = exp_rd.pop_front();
            if (rd_data !== d) begin
              errors++;
              $display("FAIL rd_data: got %h want %h", rd_data, d);
            end
          end
        end
      end
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((exp_acc.size() != 0 || exp_rd.size() != 0 || mem_ack != mem_req) && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_idle: timeout with %0d accesses and %0d reads outstanding", exp_acc.size(), exp_rd.size());
    end
    repeat (3) @(negedge clk_sys);
  endtask
  task automatic test_reset();
    int base;
    reset_n = 1'b0;
    {dl_active, dl_wr, rd_oe} = 3'b000;
    dl_addr = '0;
    dl_data = '0;
    rd_addr = '0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_ds, mem_din, rd_data, rd_valid, dl_overflow, dl_done} !== 61'd0) begin
      errors++;
      $display("FAIL reset_power_up: outputs not all zero");
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    hold = 1'b1;
    rd_addr = 22'h33;
    rd_oe = 1'b1;
    exp_acc.push_back(rd_exp(22'h33));
    @(negedge clk_sys);
    rd_oe = 1'b0;
    repeat (4) @(negedge clk_sys);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 22'h33) begin
      errors++;
      $display("FAIL reset_inflight: req=%0b we=%0b addr=%h want 1 0 000033", mem_req, mem_we, mem_addr);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_ds, mem_din, rd_data, rd_valid, dl_overflow, dl_done} !== 61'd0) begin
      errors++;
      $display("FAIL reset_mid_read: req=%0b we=%0b addr=%h ds=%b want all zero", mem_req, mem_we, mem_addr, mem_ds);
    end
    hold = 1'b0;
    exp_acc.delete();
    @(negedge clk_sys);
    #2 reset_n = 1'b1;
    base = n_req;
    repeat (10) @(negedge clk_sys);
    checks++;
    if (n_req !== base || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: %0d spurious requests, mem_req=%0b want 0", n_req - base, mem_req);
    end
  endtask
  task automatic test_single_write();
    int base = n_req;
    lat = 3;
    dl_active = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b1;
    dl_addr = 23'h000005;
    dl_data = 8'hA5;
    exp_acc.push_back(wr_exp(23'h000005, 8'hA5));
    @(negedge clk_sys);
    dl_wr = 1'b0;
    wait_idle();
    checks++;
    if (n_req - base !== 1 || mem_din !== 16'hA5A5 || mem_ds !== 2'b10 || mem_addr !== 22'h2) begin
      errors++;
      $display("FAIL single_write: reqs=%0d din=%h ds=%b addr=%h want 1 a5a5 10 000002", n_req - base, mem_din, mem_ds, mem_addr);
    end
    dl_active = 1'b0;
    repeat (4) @(negedge clk_sys);
    checks++;
    if (dl_done !== 1'b1) begin
      errors++;
      $display("FAIL dl_done_set: got %0b want 1", dl_done);
    end
  endtask
  task automatic test_overflow();
    int base;
    dl_active = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (dl_done !== 1'b0 || dl_overflow !== 1'b0) begin
      errors++;
      $display("FAIL dl_rise_clear: done=%0b overflow=%0b want 0 0", dl_done, dl_overflow);
    end
    base = n_req;
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dl_wr = 1'b1;
      dl_addr = 23'h10 + 23'(i);
      dl_data = 8'hC0 + 8'(i);
      if (i < 5) exp_acc.push_back(wr_exp(23'h10 + 23'(i), 8'hC0 + 8'(i)));
      @(negedge clk_sys);
    end
    dl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (dl_overflow !== 1'b1 || n_req - base !== 1) begin
      errors++;
      $display("FAIL overflow_flag: overflow=%0b reqs=%0d want 1 1", dl_overflow, n_req - base);
    end
    hold = 1'b0;
    wait_idle();
    checks++;
    if (n_req - base !== 5) begin
      errors++;
      $display("FAIL overflow_writes: got %0d writes want 5", n_req - base);
    end
  endtask
  task automatic test_priority();
    int base, rbase;
    dl_active = 1'b0;
    repeat (2) @(negedge clk_sys);
    dl_active = 1'b1;
    rd_addr = 22'h0;
    rd_oe = 1'b1;
    base = n_req;
    rbase = n_rdv;
    @(negedge clk_sys);
    checks++;
    if (dl_overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %0b want 0", dl_overflow);
    end
    for (int i = 0; i < 2; i++) begin
      dl_wr = 1'b1;
      dl_addr = 23'h20 + 23'(i);
      dl_data = 8'h11 * 8'(i + 1);
      exp_acc.push_back(wr_exp(23'h20 + 23'(i), 8'h11 * 8'(i + 1)));
      @(negedge clk_sys);
    end
    dl_wr = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk_sys);
    checks++;
    if (n_req - base !== 2 || n_rdv !== rbase) begin
      errors++;
      $display("FAIL priority_block: reqs=%0d reads=%0d want 2 0", n_req - base, n_rdv - rbase);
    end
    exp_acc.push_back(rd_exp(22'h0));
    exp_rd.push_back(16'h1234);
    dl_active = 1'b0;
    wait_idle();
    checks++;
    if (dl_done !== 1'b1 || rd_data !== 16'h1234 || n_rdv - rbase !== 1) begin
      errors++;
      $display("FAIL priority_read: done=%0b rd_data=%h reads=%0d want 1 1234 1", dl_done, rd_data, n_rdv - rbase);
    end
    rd_oe = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask
  task automatic test_read();
    int rbase = n_rdv;
    lat = 2;
    for (int i = 0; i < 3; i++) begin
      rd_addr = 22'h40 + 22'(i);
      rd_oe = 1'b1;
      exp_acc.push_back(rd_exp(22'h40 + 22'(i)));
      exp_rd.push_back(16'h1234 ^ (16'h40 + 16'(i)));
      @(negedge clk_sys);
      rd_oe = 1'b0;
      wait_idle();
    end
    checks++;
    if (n_rdv - rbase !== 3) begin
      errors++;
      $display("FAIL read_pulses: got %0d rd_valid pulses want 3", n_rdv - rbase);
    end
  endtask
`ifndef SDRAM_SCHED_RDCACHE_EN
  task automatic test_back_to_back();
    int rbase = n_rdv;
    lat = 5;
    rd_addr = 22'h80;
    exp_acc.push_back(rd_exp(22'h80));
    exp_acc.push_back(rd_exp(22'h80));
    exp_rd.push_back(16'h1234 ^ 16'h80);
    exp_rd.push_back(16'h1234 ^ 16'h80);
    for (int i = 0; i < 2; i++) begin
      rd_oe = 1'b1;
      @(negedge clk_sys);
      rd_oe = 1'b0;
      @(negedge clk_sys);
    end
    wait_idle();
    checks++;
    if (n_rdv - rbase !== 2) begin
      errors++;
      $display("FAIL latched_edge: got %0d reads want 2", n_rdv - rbase);
    end
  endtask
`else
  task automatic test_cache();
    int base = n_req;
    lat = 2;
    rd_addr = 22'h100;
    rd_oe = 1'b1;
    exp_acc.push_back(rd_exp(22'h100));
    exp_rd.push_back(16'h1234 ^ 16'h100);
    wait_idle();
    rd_oe = 1'b0;
    @(negedge clk_sys);
    rd_oe = 1'b1;
    repeat (8) @(negedge clk_sys);
    checks++;
    if (n_req - base !== 1) begin
      errors++;
      $display("FAIL cache_hit: got %0d accesses want 1", n_req - base);
    end
    rd_addr = 22'h101;
    exp_acc.push_back(rd_exp(22'h101));
    exp_rd.push_back(16'h1234 ^ 16'h101);
    wait_idle();
    checks++;
    if (n_req - base !== 2) begin
      errors++;
      $display("FAIL cache_miss: got %0d accesses want 2", n_req - base);
    end
    dl_active = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b1;
    dl_addr = 23'h202;
    dl_data = 8'h5A;
    exp_acc.push_back(wr_exp(23'h202, 8'h5A));
    @(negedge clk_sys);
    dl_wr = 1'b0;
    wait_idle();
    exp_acc.push_back(rd_exp(22'h101));
    exp_rd.push_back(16'h1234 ^ 16'h101);
    dl_active = 1'b0;
    wait_idle();
    checks++;
    if (n_req - base !== 4) begin
      errors++;
      $display("FAIL cache_refetch: got %0d accesses want 4", n_req - base);
    end
    rd_oe = 1'b0;
  endtask
`endif
  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    mem_ack = 1'b0;
    mem_dout = 16'h0;
    fork
      responder();
      monitor();
    join_none
    test_reset();
    test_single_write();
    test_overflow();
    test_priority();
    test_read();
`ifndef SDRAM_SCHED_RDCACHE_EN
    test_back_to_back();
`else
    test_cache();
`endif
    checks++;
    if (exp_acc.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d accesses and %0d reads never seen", exp_acc.size(), exp_rd.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
